// File: rtl/shiftreg_pkg.sv
// Shared types and defaults for the 74HC165-style chain reader.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } sr_state_e;

    localparam int unsigned SR_NBITS    = 16;
    localparam int unsigned SR_CLOCKDIV = 32;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned sr_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous header inputs, cleared by ereset.
module sync2 (
    input  logic eclk,
    input  logic ereset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/shiftreg_reader.sv
// Serial scanner for a 74HC165 chain: load strobe, shift clock, NBITS-wide word plus valid pulse.
// Define SHIFTREG_READER_CHANGE_EN to build the per-bit change mask on 'changed'.
module shiftreg_reader
    import shiftreg_pkg::*;
#(
    parameter int unsigned NBITS    = SR_NBITS,
    parameter int unsigned CLOCKDIV = SR_CLOCKDIV
) (
    input  logic             eclk,
    input  logic             ereset,
    input  logic             scan_en,
    input  logic             ser_in,
    output logic             pl_n,
    output logic             sclk,
    output logic [NBITS-1:0] data,
    output logic             valid,
    output logic [NBITS-1:0] changed
);

    localparam int unsigned CW = sr_cnt_width(CLOCKDIV);
    localparam int unsigned BW = sr_cnt_width(NBITS);

    localparam logic [CW-1:0] CntLast = CW'(CLOCKDIV - 1);
    localparam logic [CW-1:0] CntHalf = CW'(CLOCKDIV / 2);
    localparam logic [CW-1:0] CntSamp = CW'(CLOCKDIV / 2 - 1);
    localparam logic [BW-1:0] BitLast = BW'(NBITS - 1);

    sr_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [NBITS-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             pl_n_q, pl_n_d;
    logic             sclk_q, sclk_d;
    logic             frame_done;
    logic             ser_sync;

    sync2 u_sync2 (
        .eclk   (eclk),
        .ereset (ereset),
        .d_i    (ser_in),
        .q_o    (ser_sync)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        frame_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (scan_en) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (cnt_q == CntLast) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                // Sample just before sclk rises, while QH still shows the current bit.
                if (cnt_q == CntSamp) begin
                    shreg_d = NBITS'({shreg_q, ser_sync});
                end
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (bit_q == BitLast) begin
                        frame_done = 1'b1;
                        data_d     = shreg_q;
                        bit_d      = '0;
                        state_d    = scan_en ? LOAD : IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Strobes are registered from next state so the chain never sees decode glitches.
        valid_d = frame_done;
        pl_n_d  = (state_d != LOAD);
        sclk_d  = (state_d == SHIFT) && (cnt_d >= CntHalf);
    end

    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pl_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pl_n_q  <= pl_n_d;
            sclk_q  <= sclk_d;
        end
    end

`ifdef SHIFTREG_READER_CHANGE_EN
    logic [NBITS-1:0] changed_q, changed_d;

    // data_q still holds the previous frame when the new one is committed.
    always_comb begin
        changed_d = changed_q;
        if (frame_done) begin
            changed_d = shreg_q ^ data_q;
        end
    end

    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            changed_q <= '0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;
`else
    assign changed = '0;
`endif

    assign pl_n  = pl_n_q;
    assign sclk  = sclk_q;
    assign data  = data_q;
    assign valid = valid_q;

endmodule
